// File: rtl/spi_pkg.sv
// Shared types and constants for the 32-bit SPI master: one-hot phase states,
// counter widths and the phase-length-to-load-value helper.
package spi_pkg;

  localparam int unsigned SPI_WORD_W = 32;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned BIT_CNT_W  = 5;

  typedef enum logic [7:0] {
    S_IDLE  = 8'b0000_0001,
    S_SETUP = 8'b0000_0010,
    S_LOW   = 8'b0000_0100,
    S_HIGH  = 8'b0000_1000,
    S_HOLD  = 8'b0001_0000,
    S_GAP   = 8'b0010_0000
  } state_e;

  // A phase of n cycles loads n-1; a zero-length phase still spends one cycle.
  function automatic logic [CNT_W-1:0] phase_load(input int unsigned n);
    logic [CNT_W-1:0] r;
    if (n == 32'd0) begin
      r = {CNT_W{1'b0}};
    end else begin
      r = CNT_W'(n - 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter shared by every timed SPI phase; tc_o is high while
// the count sits at zero, marking the final cycle of the current phase.
module spi_phase_timer
  import spi_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/spi_master.sv
// 32-bit SPI master, mode 0, LSB first: one CS_n-framed transfer per accepted
// word, received word returned on a one-cycle rx_valid pulse.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SPI_WORD_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_WORD_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  CS_n
);

  localparam logic [CNT_W-1:0] LD_DIV   = phase_load(CLK_DIV);
  localparam logic [CNT_W-1:0] LD_SETUP = phase_load(CS_SETUP);
  localparam logic [CNT_W-1:0] LD_HOLD  = phase_load(CS_HOLD);
  localparam logic [CNT_W-1:0] LD_GAP   = phase_load(CS_IDLE);
  localparam logic             HAS_SETUP = (CS_SETUP != 32'd0);
  localparam logic             HAS_HOLD  = (CS_HOLD != 32'd0);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = 5'd31;

  state_e                  state_q, state_d;
  logic [SPI_WORD_W-1:0]   tx_sr_q, tx_sr_d;
  logic [SPI_WORD_W-1:0]   rx_sr_q, rx_sr_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic                    cs_n_q, cs_n_d;
  logic                    tx_ready_q, tx_ready_d;
  logic                    busy_q, busy_d;
  logic [SPI_WORD_W-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    tmr_load_s;
  logic [CNT_W-1:0]        tmr_val_s;
  logic                    tmr_tc_s;

  spi_phase_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .tc_o       (tmr_tc_s)
  );

  // Phase sequencing and next values of every registered SPI output.
  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = LD_DIV;

    case (state_q)
      S_IDLE: begin
        tx_ready_d = 1'b1;
        if (tx_valid && tx_ready_q) begin
          // Bit 0 goes straight to MOSI; the rest waits pre-shifted.
          tx_sr_d    = {1'b0, tx_data[SPI_WORD_W-1:1]};
          mosi_d     = tx_data[0];
          cs_n_d     = 1'b0;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
          bit_cnt_d  = {BIT_CNT_W{1'b0}};
          tmr_load_s = 1'b1;
          if (HAS_SETUP) begin
            state_d   = S_SETUP;
            tmr_val_s = LD_SETUP;
          end else begin
            state_d   = S_LOW;
            tmr_val_s = LD_DIV;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETUP: begin
        if (tmr_tc_s) begin
          state_d    = S_LOW;
          tmr_load_s = 1'b1;
          tmr_val_s  = LD_DIV;
        end else begin
          state_d = S_SETUP;
        end
      end

      S_LOW: begin
        if (tmr_tc_s) begin
          rx_sr_d    = {MISO, rx_sr_q[SPI_WORD_W-1:1]};
          sclk_d     = 1'b1;
          state_d    = S_HIGH;
          tmr_load_s = 1'b1;
          tmr_val_s  = LD_DIV;
        end else begin
          state_d = S_LOW;
        end
      end

      S_HIGH: begin
        if (tmr_tc_s) begin
          sclk_d     = 1'b0;
          tmr_load_s = 1'b1;
          if (bit_cnt_q != LAST_BIT) begin
            tx_sr_d   = {1'b0, tx_sr_q[SPI_WORD_W-1:1]};
            mosi_d    = tx_sr_q[0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = S_LOW;
            tmr_val_s = LD_DIV;
          end else if (HAS_HOLD) begin
            mosi_d    = 1'b0;
            state_d   = S_HOLD;
            tmr_val_s = LD_HOLD;
          end else begin
            // No hold time: close the frame on the same edge as the last fall.
            mosi_d     = 1'b0;
            cs_n_d     = 1'b1;
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            state_d    = S_GAP;
            tmr_val_s  = LD_GAP;
          end
        end else begin
          state_d = S_HIGH;
        end
      end

      S_HOLD: begin
        if (tmr_tc_s) begin
          cs_n_d     = 1'b1;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          state_d    = S_GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = LD_GAP;
        end else begin
          state_d = S_HOLD;
        end
      end

      S_GAP: begin
        // Gap lasts at least one cycle so rx_valid never meets tx_ready.
        if (tmr_tc_s) begin
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end

      default: begin
        state_d    = S_IDLE;
        sclk_d     = 1'b0;
        mosi_d     = 1'b0;
        cs_n_d     = 1'b1;
        tx_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer on the spot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_sr_q    <= {SPI_WORD_W{1'b0}};
      rx_sr_q    <= {SPI_WORD_W{1'b0}};
      bit_cnt_q  <= {BIT_CNT_W{1'b0}};
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= {SPI_WORD_W{1'b0}};
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign CS_n     = cs_n_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default-timing instance plus a minimum-timing
// instance (CLK_DIV=1, no setup/hold/idle), MISO from loopback, ties or a slave model.
module tb_spi_master;

  logic        clk;
  logic        reset;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        sel;
  logic [1:0]  mode;

  logic        tx_valid0, tx_valid1;
  logic        d0_ready, d0_rxv, d0_busy, d0_sclk, d0_mosi, d0_csn, d0_miso;
  logic        d1_ready, d1_rxv, d1_busy, d1_sclk, d1_mosi, d1_csn, d1_miso;
  logic [31:0] d0_rx_data, d1_rx_data;

  logic        o_ready, o_rxv, o_busy, o_sclk, o_mosi, o_csn;
  logic [31:0] o_rx_data;

  int          n_err;
  int          n_checks;
  int          cyc;

  logic [31:0] slv_sr;
  logic        slv_sclk_p;

  int          t0, t_cs_low, t_cs_high, t_first_rise, t_last_fall, t_rxv, t_ready;
  int          n_rise, n_rxv;
  logic        ovl, busy_first, ready_first, timed_out;
  logic [31:0] mosi_bits, rx_word;

  time         t_rst, t_csn_rise, t_sclk_fall, t_mosi_fall;

  spi_master u_dut0 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid0),
    .tx_ready(d0_ready), .rx_data(d0_rx_data), .rx_valid(d0_rxv), .busy(d0_busy),
    .SCLK(d0_sclk), .MOSI(d0_mosi), .MISO(d0_miso), .CS_n(d0_csn)
  );

  spi_master #(.CLK_DIV(1), .CS_SETUP(0), .CS_HOLD(0), .CS_IDLE(0)) u_dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid1),
    .tx_ready(d1_ready), .rx_data(d1_rx_data), .rx_valid(d1_rxv), .busy(d1_busy),
    .SCLK(d1_sclk), .MOSI(d1_mosi), .MISO(d1_miso), .CS_n(d1_csn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign tx_valid0 = tx_valid & ~sel;
  assign tx_valid1 = tx_valid & sel;
  assign d1_miso   = d1_mosi;

  always_comb begin
    case (mode)
      2'd0:    d0_miso = d0_mosi;
      2'd1:    d0_miso = 1'b1;
      2'd2:    d0_miso = 1'b0;
      default: d0_miso = slv_sr[0];
    endcase
  end

  assign o_ready   = sel ? d1_ready   : d0_ready;
  assign o_rxv     = sel ? d1_rxv     : d0_rxv;
  assign o_busy    = sel ? d1_busy    : d0_busy;
  assign o_sclk    = sel ? d1_sclk    : d0_sclk;
  assign o_mosi    = sel ? d1_mosi    : d0_mosi;
  assign o_csn     = sel ? d1_csn     : d0_csn;
  assign o_rx_data = sel ? d1_rx_data : d0_rx_data;

  // Slave model: reloads while deselected, advances one bit after each SCLK fall.
  always @(posedge clk) begin
    slv_sclk_p <= d0_sclk;
    if (d0_csn) slv_sr <= 32'hDEAD_BEEF;
    else if (slv_sclk_p && !d0_sclk) slv_sr <= {1'b0, slv_sr[31:1]};
  end

  always @(posedge d0_csn) t_csn_rise <= $time;
  always @(negedge d0_sclk) t_sclk_fall <= $time;
  always @(negedge d0_mosi) t_mosi_fall <= $time;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer on the selected DUT and records its waveform events.
  task automatic run_xfer(input logic [31:0] data, input logic hold_valid, input logic [31:0] next_data);
    int n;
    logic p_sclk, p_cs;
    tx_data  = data;
    tx_valid = 1'b1;
    n = 0;
    while (o_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", {31'd0, (n < 1000)}, 32'd1);
    t0 = cyc;
    t_cs_low = -1; t_cs_high = -1; t_first_rise = -1; t_last_fall = -1;
    t_rxv = -1; t_ready = -1; n_rise = 0; n_rxv = 0; ovl = 1'b0;
    mosi_bits = 32'd0; rx_word = 32'd0; timed_out = 1'b1;
    p_sclk = 1'b0;
    p_cs   = 1'b1;
    @(posedge clk);
    #1;
    tx_data  = next_data;
    tx_valid = hold_valid;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (k == 0) begin
        busy_first  = o_busy;
        ready_first = o_ready;
      end
      if (p_cs && !o_csn && t_cs_low < 0) t_cs_low = cyc;
      if (!p_cs && o_csn) t_cs_high = cyc;
      if (!p_sclk && o_sclk && !o_csn) begin
        if (n_rise == 0) t_first_rise = cyc;
        if (n_rise < 32) mosi_bits[n_rise[4:0]] = o_mosi;
        n_rise++;
      end
      if (p_sclk && !o_sclk) t_last_fall = cyc;
      if (o_rxv) begin
        n_rxv++;
        t_rxv   = cyc;
        rx_word = o_rx_data;
        if (o_ready) ovl = 1'b1;
      end
      p_cs   = o_csn;
      p_sclk = o_sclk;
      if (o_ready) begin
        t_ready   = cyc;
        timed_out = 1'b0;
        break;
      end
    end
    chk("xfer_timeout", {31'd0, timed_out}, 32'd0);
  endtask

  // Compares the recorded events of the last transfer with expected timing/data.
  task automatic chk_xfer(input string tag, input logic [31:0] exp_rx, input logic [31:0] exp_tx,
                          input int e_rise, input int e_fall, input int e_cs_high, input int e_ready);
    chk({tag, "_busy_t1"},    {31'd0, busy_first},  32'd1);
    chk({tag, "_ready_t1"},   {31'd0, ready_first}, 32'd0);
    chk({tag, "_cs_low"},     t_cs_low - t0,        32'd1);
    chk({tag, "_first_rise"}, t_first_rise - t0,    e_rise);
    chk({tag, "_last_fall"},  t_last_fall - t0,     e_fall);
    chk({tag, "_cs_high"},    t_cs_high - t0,       e_cs_high);
    chk({tag, "_rxv_time"},   t_rxv - t0,           e_cs_high);
    chk({tag, "_ready_time"}, t_ready - t0,         e_ready);
    chk({tag, "_n_rise"},     n_rise,               32'd32);
    chk({tag, "_n_rxv"},      n_rxv,                32'd1);
    chk({tag, "_rxv_ready"},  {31'd0, ovl},         32'd0);
    chk({tag, "_mosi_bits"},  mosi_bits,            exp_tx);
    chk({tag, "_rx_word"},    rx_word,              exp_rx);
    chk({tag, "_rx_held"},    o_rx_data,            exp_rx);
    chk({tag, "_idle_lines"}, {29'd0, o_csn, o_sclk, o_mosi}, 32'd4);
  endtask

  initial begin
    int t_cs_high1, t_ready1, rises;
    logic [31:0] rx1;
    logic p_s, rxv_seen;
    n_err = 0; n_checks = 0;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 32'd0; sel = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clk);

    chk("rst_csn",    {31'd0, d0_csn},   32'd1);
    chk("rst_sclk",   {31'd0, d0_sclk},  32'd0);
    chk("rst_mosi",   {31'd0, d0_mosi},  32'd0);
    chk("rst_ready",  {31'd0, d0_ready}, 32'd0);
    chk("rst_rxv",    {31'd0, d0_rxv},   32'd0);
    chk("rst_busy",   {31'd0, d0_busy},  32'd0);
    chk("rst_rxdata", d0_rx_data,        32'd0);
    reset = 1'b0;
    chk("rel_ready_pre", {31'd0, d0_ready}, 32'd0);
    @(negedge clk);
    chk("rel_ready_post", {31'd0, d0_ready}, 32'd1);

    mode = 2'd0;
    run_xfer(32'hA5A5_0F0F, 1'b0, 32'h0);
    chk_xfer("loop", 32'hA5A5_0F0F, 32'hA5A5_0F0F, 7, 259, 261, 265);

    mode = 2'd1;
    run_xfer(32'h0000_0000, 1'b0, 32'h0);
    chk_xfer("tie1", 32'hFFFF_FFFF, 32'h0000_0000, 7, 259, 261, 265);

    mode = 2'd2;
    run_xfer(32'hFFFF_FFFF, 1'b0, 32'h0);
    chk_xfer("tie0", 32'h0000_0000, 32'hFFFF_FFFF, 7, 259, 261, 265);

    mode = 2'd3;
    run_xfer(32'h1234_5678, 1'b0, 32'h0);
    chk_xfer("slave", 32'hDEAD_BEEF, 32'h1234_5678, 7, 259, 261, 265);

    mode = 2'd0;
    run_xfer(32'h0000_0001, 1'b1, 32'h0000_0002);
    t_cs_high1 = t_cs_high; t_ready1 = t_ready; rx1 = rx_word;
    run_xfer(32'h0000_0002, 1'b0, 32'hFFFF_0000);
    chk("b2b_rx1",       rx1,                       32'h0000_0001);
    chk("b2b_rx2",       rx_word,                   32'h0000_0002);
    chk("b2b_accept",    t0 - t_ready1,             32'd0);
    chk("b2b_cs_high_n", t_cs_low - t_cs_high1,     32'd5);

    tx_data = 32'hFFFF_FFFF; tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    rises = 0; p_s = 1'b0;
    for (int k = 0; k < 400 && rises < 11; k++) begin
      @(negedge clk);
      if (!p_s && d0_sclk) rises++;
      p_s = d0_sclk;
    end
    chk("rst_reach_bit10", rises, 32'd11);
    chk("rst_pre_csn",  {31'd0, d0_csn},  32'd0);
    chk("rst_pre_mosi", {31'd0, d0_mosi}, 32'd1);
    #3;
    t_rst = $time;
    reset = 1'b1;
    #1;
    chk("rst_mid_csn",  {31'd0, d0_csn},  32'd1);
    chk("rst_mid_sclk", {31'd0, d0_sclk}, 32'd0);
    chk("rst_mid_mosi", {31'd0, d0_mosi}, 32'd0);
    chk("rst_mid_busy", {31'd0, d0_busy}, 32'd0);
    chk("rst_async_csn",  {31'd0, (t_csn_rise == t_rst)},  32'd1);
    chk("rst_async_sclk", {31'd0, (t_sclk_fall == t_rst)}, 32'd1);
    chk("rst_async_mosi", {31'd0, (t_mosi_fall == t_rst)}, 32'd1);
    rxv_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d0_rxv) rxv_seen = 1'b1;
    end
    chk("rst_mid_rxdata", d0_rx_data, 32'd0);
    reset = 1'b0;
    chk("rst_rel_ready0", {31'd0, d0_ready}, 32'd0);
    @(negedge clk);
    chk("rst_rel_ready1", {31'd0, d0_ready}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      if (d0_rxv) rxv_seen = 1'b1;
    end
    chk("rst_no_rxv", {31'd0, rxv_seen}, 32'd0);

    sel = 1'b1; mode = 2'd0;
    run_xfer(32'h8000_0001, 1'b0, 32'h0);
    chk_xfer("fast", 32'h8000_0001, 32'h8000_0001, 2, 65, 65, 66);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
